adc_delay_calib: RTL
====================

Name: adc_delay_calib

Overview:
Calibration controller for the ADC input-delay taps of the DDR SelectIO input buffer. On command it sweeps the shared 5-bit data-delay tap over all 32 settings and checks the packed 26-bit ADC word against a known test pattern at each setting. It then locates the longest contiguous passing window and programs the tap to the window centre. It sits in the adc_clk domain and drives the buffer's delay-tap and delay-reset inputs in place of static register values. It also supports a direct manual tap load.

Parameters:
SETTLE_CYCLES, 16, clocks waited after each tap load before checking starts (min 2)
CHECK_CYCLES, 256, consecutive words compared per tap (min 1)

Ports:
clk  input  1  adc_clk; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
cal_start  input  1  single-cycle request to start a sweep; accepted only in IDLE
manual_load  input  1  single-cycle request to apply manual_tap; accepted only in IDLE
manual_tap  input  5  tap value for manual_load
sample_dat  input  26  packed SDR word from the input buffer, valid every clk
expected_dat  input  26  test-pattern word; held constant during a sweep
delay_tap  output  5  tap value to the buffer, all 13 lines
delay_reset  output  1  one-cycle load strobe for delay_tap
cal_busy  output  1  high from cal_start acceptance until DONE exits
cal_done  output  1  sticky; set in DONE, cleared when the next cal_start is accepted
cal_fail  output  1  sticky; set when no tap passed, cleared when the next cal_start is accepted
pass_map  output  32  bit[t]=1 when tap t passed; cleared when a sweep starts
win_start  output  5  first tap of the best window
win_len  output  6  length of the best window (0..32)

Behaviour:
- Reset values when reset_n=0 at an edge: delay_tap=0, delay_reset=0, cal_busy=0, cal_done=0, cal_fail=0, pass_map=0, win_start=0, win_len=0, state=IDLE, all counters 0. Reset mid-sweep aborts immediately with no delay_reset strobe.
- sample_dat is registered once before comparison. Word error = (registered sample_dat != expected_dat), compared on all 26 bits.
- IDLE:
  - cal_start → save current delay_tap as prev_tap; set tap counter=0; clear pass_map, win_*, cal_done, cal_fail; set cal_busy=1; go to SET_TAP.
  - manual_load (without cal_start) → delay_tap<=manual_tap on the next edge; delay_reset=1 for that same single cycle; stay in IDLE.
  - If cal_start and manual_load arrive together, cal_start wins and manual_load is dropped.
  - Requests arriving outside IDLE are ignored.
- SET_TAP (1 cycle): delay_tap=tap counter, delay_reset=1. delay_tap is valid in the same cycle as the strobe and is held afterwards. Go to SETTLE.
- SETTLE: count SETTLE_CYCLES clocks, then go to CHECK with the error flag cleared.
- CHECK: count CHECK_CYCLES clocks. The error flag is sticky: it ORs in every word error. Go to RECORD.
- RECORD (1 cycle):
  - pass_map[tap]=~err.
  - Run tracking: on pass, run_len+1, and run_start=tap when the run was empty. On fail, run_len=0.
  - If the updated run_len > best_len (strictly greater), copy run_start/run_len into win_start/win_len. Ties keep the lower window.
  - Windows do not wrap from tap 31 to tap 0.
  - If tap==31 go to APPLY; otherwise increment tap and go to SET_TAP.
- APPLY (1 cycle):
  - win_len>0: delay_tap=win_start+((win_len-1)>>1), 5-bit result, cannot overflow.
  - win_len==0: delay_tap=prev_tap and cal_fail=1.
  - delay_reset=1 in both cases. Go to DONE.
- DONE (1 cycle): cal_done=1, then cal_busy=0 on exit to IDLE.
- Sweep length: 32×(SETTLE_CYCLES+CHECK_CYCLES+2)+2 clocks after acceptance, i.e. 8770 with defaults.
- delay_reset is high in exactly 33 cycles per sweep and is otherwise 0 outside SET_TAP/APPLY/manual load.

Test Plan:
- Constant matching pattern, all taps pass: cal_start → pass_map=0xFFFFFFFF, win_start=0, win_len=32, final delay_tap=15, cal_done=1, cal_fail=0, 33 delay_reset strobes, cal_busy high for 8770 clocks.
- Pattern corrupted except while delay_tap∈[10,20]: pass_map=0x001FFC00, win_start=10, win_len=11, final delay_tap=15.
- Passing taps 3..6 and 20..23 (equal length): win_start=3, win_len=4, final delay_tap=4. Variant with taps 20..24 passing: win_start=20, win_len=5, delay_tap=22.
- One corrupted word anywhere in a tap's CHECK window (including the first and last word): that tap's bit is 0. Also: manual_load with manual_tap=7, then a sweep where no tap passes: cal_fail=1, win_len=0, final delay_tap=7.
- reset_n=0 during CHECK at tap 12: all outputs at reset values on the next cycle, no further delay_reset. A new cal_start after reset runs a full sweep normally.
- cal_start and manual_load pulsed while cal_busy=1: no effect on sweep timing or results. cal_start and manual_load together in IDLE: sweep starts and manual_tap is not applied.

Source files
------------

// File: rtl/adc_delay_calib.sv
// Sweeps the shared ADC input-delay tap over 32 settings, checks each tap against the
// test pattern, then loads the centre of the longest passing window (or restores the old tap).
module adc_delay_calib #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CHECK_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cal_start,
    input  logic        manual_load,
    input  logic [4:0]  manual_tap,
    input  logic [25:0] sample_dat,
    input  logic [25:0] expected_dat,
    output logic [4:0]  delay_tap,
    output logic        delay_reset,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_fail,
    output logic [31:0] pass_map,
    output logic [4:0]  win_start,
    output logic [5:0]  win_len
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SET_TAP = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_RECORD  = 3'd4;
    localparam logic [2:0] S_APPLY   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam int unsigned MAX_CYC = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    logic [2:0]       state_q, state_d;
    logic [4:0]       tap_cnt_q, tap_cnt_d;
    logic [4:0]       prev_tap_q, prev_tap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [25:0]      sample_q;
    logic [4:0]       run_start_q, run_start_d;
    logic [5:0]       run_len_q, run_len_d;
    logic [4:0]       delay_tap_q, delay_tap_d;
    logic             delay_reset_q, delay_reset_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [31:0]      pass_map_q, pass_map_d;
    logic [4:0]       win_start_q, win_start_d;
    logic [5:0]       win_len_q, win_len_d;
    logic             word_err;
    logic             tap_pass;

    assign word_err = (sample_q != expected_dat);
    assign tap_pass = ~err_q;

    always_comb begin
        state_d       = state_q;
        tap_cnt_d     = tap_cnt_q;
        prev_tap_d    = prev_tap_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        run_start_d   = run_start_q;
        run_len_d     = run_len_q;
        delay_tap_d   = delay_tap_q;
        delay_reset_d = 1'b0;
        busy_d        = busy_q;
        done_d        = done_q;
        fail_d        = fail_q;
        pass_map_d    = pass_map_q;
        win_start_d   = win_start_q;
        win_len_d     = win_len_q;

        case (state_q)
            S_IDLE: begin
                if (cal_start) begin
                    prev_tap_d    = delay_tap_q;
                    tap_cnt_d     = '0;
                    pass_map_d    = '0;
                    win_start_d   = '0;
                    win_len_d     = '0;
                    run_start_d   = '0;
                    run_len_d     = '0;
                    done_d        = 1'b0;
                    fail_d        = 1'b0;
                    busy_d        = 1'b1;
                    delay_tap_d   = '0;
                    delay_reset_d = 1'b1;
                    state_d       = S_SET_TAP;
                end else if (manual_load) begin
                    delay_tap_d   = manual_tap;
                    delay_reset_d = 1'b1;
                end
            end
            S_SET_TAP: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                err_d = err_q | word_err;
                if (cnt_q == CNT_W'(CHECK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RECORD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RECORD: begin
                pass_map_d[tap_cnt_q] = tap_pass;
                if (tap_pass) begin
                    if (run_len_q == 6'd0) run_start_d = tap_cnt_q;
                    run_len_d = run_len_q + 6'd1;
                end else begin
                    run_len_d = '0;
                end
                if (run_len_d > win_len_q) begin
                    win_start_d = run_start_d;
                    win_len_d   = run_len_d;
                end
                // Tap and strobe are registered, so the next state's values are loaded here
                // to appear during SET_TAP / APPLY themselves.
                delay_reset_d = 1'b1;
                if (tap_cnt_q == 5'd31) begin
                    if (win_len_d != 6'd0) begin
                        delay_tap_d = win_start_d + 5'((win_len_d - 6'd1) >> 1);
                    end else begin
                        delay_tap_d = prev_tap_q;
                        fail_d      = 1'b1;
                    end
                    state_d = S_APPLY;
                end else begin
                    tap_cnt_d   = tap_cnt_q + 5'd1;
                    delay_tap_d = tap_cnt_q + 5'd1;
                    state_d     = S_SET_TAP;
                end
            end
            S_APPLY: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            tap_cnt_q     <= '0;
            prev_tap_q    <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            sample_q      <= '0;
            run_start_q   <= '0;
            run_len_q     <= '0;
            delay_tap_q   <= '0;
            delay_reset_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            pass_map_q    <= '0;
            win_start_q   <= '0;
            win_len_q     <= '0;
        end else begin
            state_q       <= state_d;
            tap_cnt_q     <= tap_cnt_d;
            prev_tap_q    <= prev_tap_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            sample_q      <= sample_dat;
            run_start_q   <= run_start_d;
            run_len_q     <= run_len_d;
            delay_tap_q   <= delay_tap_d;
            delay_reset_q <= delay_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            pass_map_q    <= pass_map_d;
            win_start_q   <= win_start_d;
            win_len_q     <= win_len_d;
        end
    end

    assign delay_tap   = delay_tap_q;
    assign delay_reset = delay_reset_q;
    assign cal_busy    = busy_q;
    assign cal_done    = done_q;
    assign cal_fail    = fail_q;
    assign pass_map    = pass_map_q;
    assign win_start   = win_start_q;
    assign win_len     = win_len_q;

endmodule
